rshp_job_sched: RTL and testbench

Descriptor scheduler directly upstream of the reshaper engine. It queues reshape jobs from the control plane and holds each job's configuration stable on the engine's config ports. It issues the one-cycle `init_pulse`, waits for the engine's `finish` under a watchdog, and reports per-job completion. It never touches the data path.

---
 rtl/rshp_job_sched_if.sv | 41 ++++
 rtl/rshp_job_sched.sv | 95 +++++++++
 tb/tb_rshp_job_sched.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rshp_job_sched_if.sv
// rshp_job_sched_if: descriptor intake, engine config and completion status bundle for the job scheduler
interface rshp_job_sched_if #(
  parameter int AW = 16,
  parameter int ADIM = 6,
  parameter int QD = 4,
  parameter int TOW = 24
);
  logic enable;
  logic desc_vld;
  logic desc_rdy;
  logic [7:0] desc_tag;
  logic [AW-1:0] desc_rreq_num, desc_raddr_base, desc_wreq_num, desc_waddr_base, desc_rdata_size, desc_wdata_size;
  logic [ADIM-1:0][AW-1:0] desc_raddr_size, desc_raddr_stride, desc_waddr_size, desc_waddr_stride;
  logic [TOW-1:0] timeout_limit;
  logic [AW-1:0] rreq_num, raddr_base, wreq_num, waddr_base, rdata_size, wdata_size;
  logic [ADIM-1:0][AW-1:0] raddr_size, raddr_stride, waddr_size, waddr_stride;
  logic init_pulse;
  logic finish;
  logic busy;
  logic job_done;
  logic [7:0] job_tag;
  logic job_err;
  logic [AW-1:0] done_cnt;
  logic [$clog2(QD):0] q_level;
  modport slave (
    input enable, desc_vld, desc_tag, desc_rreq_num, desc_raddr_base, desc_wreq_num, desc_waddr_base,
          desc_rdata_size, desc_wdata_size, desc_raddr_size, desc_raddr_stride, desc_waddr_size,
          desc_waddr_stride, timeout_limit, finish,
    output desc_rdy, rreq_num, raddr_base, wreq_num, waddr_base, rdata_size, wdata_size, raddr_size,
           raddr_stride, waddr_size, waddr_stride, init_pulse, busy, job_done, job_tag, job_err,
           done_cnt, q_level
  );
  modport master (
    output enable, desc_vld, desc_tag, desc_rreq_num, desc_raddr_base, desc_wreq_num, desc_waddr_base,
           desc_rdata_size, desc_wdata_size, desc_raddr_size, desc_raddr_stride, desc_waddr_size,
           desc_waddr_stride, timeout_limit, finish,
    input desc_rdy, rreq_num, raddr_base, wreq_num, waddr_base, rdata_size, wdata_size, raddr_size,
          raddr_stride, waddr_size, waddr_stride, init_pulse, busy, job_done, job_tag, job_err,
          done_cnt, q_level
  );
endinterface

// File: rtl/rshp_job_sched.sv
// rshp_job_sched: queues reshape descriptors, holds config stable, kicks the engine and reports completion under a watchdog
module rshp_job_sched #(
  parameter int AW = 16,
  parameter int ADIM = 6,
  parameter int QD = 4,
  parameter int TOW = 24
) (
  input logic clk,
  input logic reset_n,
  rshp_job_sched_if.slave bus
);
  localparam int PW = $clog2(QD);
  typedef struct packed {
    logic [7:0] tag;
    logic [AW-1:0] rreq_num, raddr_base, wreq_num, waddr_base, rdata_size, wdata_size;
    logic [ADIM-1:0][AW-1:0] raddr_size, raddr_stride, waddr_size, waddr_stride;
  } desc_t;
  typedef enum logic [2:0] {IDLE, LOAD, KICK, RUN, DONE} state_t;
  state_t state, nxt;
  desc_t mem [QD];
  desc_t cfg, din;
  logic [PW-1:0] wp, rp;
  logic [PW:0] cnt;
  logic [TOW-1:0] wd, lim;
  logic push, pop, tmo;
  assign din = {bus.desc_tag, bus.desc_rreq_num, bus.desc_raddr_base, bus.desc_wreq_num, bus.desc_waddr_base,
                bus.desc_rdata_size, bus.desc_wdata_size, bus.desc_raddr_size, bus.desc_raddr_stride,
                bus.desc_waddr_size, bus.desc_waddr_stride};
  assign bus.desc_rdy = (cnt < (PW+1)'(QD)) & reset_n;
  assign push = bus.desc_vld & bus.desc_rdy;
  assign pop = (state == IDLE) & (nxt == LOAD);
  assign tmo = (lim != '0) && (wd == lim - TOW'(1));
  assign bus.busy = state != IDLE;
  assign bus.q_level = cnt;
  assign bus.rreq_num = cfg.rreq_num;
  assign bus.raddr_base = cfg.raddr_base;
  assign bus.wreq_num = cfg.wreq_num;
  assign bus.waddr_base = cfg.waddr_base;
  assign bus.rdata_size = cfg.rdata_size;
  assign bus.wdata_size = cfg.wdata_size;
  assign bus.raddr_size = cfg.raddr_size;
  assign bus.raddr_stride = cfg.raddr_stride;
  assign bus.waddr_size = cfg.waddr_size;
  assign bus.waddr_stride = cfg.waddr_stride;
  // descriptor FIFO; a pop never frees a slot for a same-cycle push because desc_rdy looks only at the count
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + PW'(push);
      rp <= rp + PW'(pop);
      cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
  // state register
  always_ff @(posedge clk) state <= !reset_n ? IDLE : nxt;
  // next state; zero-write jobs skip the engine since it would never finish them, and finish beats timeout
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = (bus.enable && cnt != '0) ? LOAD : IDLE;
      LOAD: nxt = (cfg.wreq_num == '0) ? DONE : KICK;
      KICK: nxt = RUN;
      RUN: nxt = (bus.finish || tmo) ? DONE : RUN;
      default: nxt = IDLE;
    endcase
  end
  // registered config, strobes, completion status and the saturating watchdog
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cfg <= '0;
      bus.init_pulse <= 1'b0;
      bus.job_done <= 1'b0;
      bus.job_tag <= '0;
      bus.job_err <= 1'b0;
      bus.done_cnt <= '0;
      wd <= '0;
      lim <= '0;
    end else begin
      bus.init_pulse <= nxt == KICK;
      bus.job_done <= nxt == DONE;
      if (pop) cfg <= mem[rp];
      if (nxt == DONE) begin
        bus.job_tag <= cfg.tag;
        bus.job_err <= (state == RUN) && !bus.finish;
        bus.done_cnt <= bus.done_cnt + AW'(1);
      end
      wd <= (state == KICK) ? '0 : ((state == RUN) && (wd != '1)) ? wd + TOW'(1) : wd;
      if (state == KICK) lim <= bus.timeout_limit;
    end
  end
endmodule

// File: tb/tb_rshp_job_sched.sv
// tb_rshp_job_sched: directed sequence with randomized descriptors checked against a job-queue model
module tb_rshp_job_sched;
  localparam int AW = 16, ADIM = 6, QD = 4, TOW = 24;
  typedef struct packed {
    logic [7:0] tag;
    logic [AW-1:0] rreq_num, raddr_base, wreq_num, waddr_base, rdata_size, wdata_size;
    logic [ADIM-1:0][AW-1:0] raddr_size, raddr_stride, waddr_size, waddr_stride;
  } job_t;
  logic clk = 1'b0;
  logic reset_n;
  int checks = 0;
  int errors = 0;
  job_t exp_q[$];
  job_t cur;
  logic [AW-1:0] exp_done;
  rshp_job_sched_if #(.AW(AW), .ADIM(ADIM), .QD(QD), .TOW(TOW)) b();
  rshp_job_sched #(.AW(AW), .ADIM(ADIM), .QD(QD), .TOW(TOW)) dut (.clk(clk), .reset_n(reset_n), .bus(b));
  always #5 clk = ~clk;
  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [479:0] job_cfg(input job_t j);
    return {j.rreq_num, j.raddr_base, j.wreq_num, j.waddr_base, j.rdata_size, j.wdata_size,
            j.raddr_size, j.raddr_stride, j.waddr_size, j.waddr_stride};
  endfunction
  function automatic logic [479:0] dut_cfg();
    return {b.rreq_num, b.raddr_base, b.wreq_num, b.waddr_base, b.rdata_size, b.wdata_size,
            b.raddr_size, b.raddr_stride, b.waddr_size, b.waddr_stride};
  endfunction
  function automatic job_t rnd_job(input logic [7:0] tag, input logic [AW-1:0] wreq);
    job_t j;
    j.tag = tag;
    j.rreq_num = AW'($urandom);
    j.raddr_base = AW'($urandom);
    j.wreq_num = wreq;
    j.waddr_base = AW'($urandom);
    j.rdata_size = AW'($urandom);
    j.wdata_size = AW'($urandom);
    for (int i = 0; i < ADIM; i++) begin
      j.raddr_size[i] = AW'($urandom);
      j.raddr_stride[i] = AW'($urandom);
      j.waddr_size[i] = AW'($urandom);
      j.waddr_stride[i] = AW'($urandom);
    end
    return j;
  endfunction
  function automatic logic [AW-1:0] nz();
    return AW'($urandom_range(1, (1 << AW) - 1));
  endfunction
  task automatic offer(input job_t j);
    cur = j;
    b.desc_vld = 1'b1;
    b.desc_tag = j.tag;
    b.desc_rreq_num = j.rreq_num;
    b.desc_raddr_base = j.raddr_base;
    b.desc_wreq_num = j.wreq_num;
    b.desc_waddr_base = j.waddr_base;
    b.desc_rdata_size = j.rdata_size;
    b.desc_wdata_size = j.wdata_size;
    b.desc_raddr_size = j.raddr_size;
    b.desc_raddr_stride = j.raddr_stride;
    b.desc_waddr_size = j.waddr_size;
    b.desc_waddr_stride = j.waddr_stride;
  endtask
  task automatic step();
    logic acc;
    acc = b.desc_vld && b.desc_rdy;
    @(posedge clk);
    #1;
    if (acc === 1'b1) begin
      exp_q.push_back(cur);
      b.desc_vld = 1'b0;
    end
  endtask
  task automatic wait_init(output int n);
    n = 0;
    while (b.init_pulse !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk("init_seen", b.init_pulse, 1);
  endtask
  task automatic finish_job(input int d, input bit kick_fin);
    bit early = 1'b0;
    job_t e = exp_q[0];
    chk("cfg", dut_cfg(), job_cfg(e));
    for (int i = 0; i < d; i++) begin
      if (i == 0 && kick_fin) b.finish = 1'b1;
      step();
      b.finish = 1'b0;
      if (b.job_done === 1'b1) early = 1'b1;
    end
    b.finish = 1'b1;
    step();
    b.finish = 1'b0;
    chk("early_done", early, 0);
    chk("job_done", b.job_done, 1);
    chk("job_tag", b.job_tag, e.tag);
    chk("job_err", b.job_err, 0);
    void'(exp_q.pop_front());
    exp_done++;
    step();
    chk("done_cnt", b.done_cnt, exp_done);
    chk("done_one_cycle", b.job_done, 0);
  endtask
  task automatic timeout_job(input int lmt);
    bit early = 1'b0;
    job_t e = exp_q[0];
    for (int i = 0; i < lmt; i++) begin
      step();
      if (b.job_done === 1'b1) early = 1'b1;
    end
    step();
    chk("to_early", early, 0);
    chk("to_done", b.job_done, 1);
    chk("to_err", b.job_err, 1);
    chk("to_tag", b.job_tag, e.tag);
    void'(exp_q.pop_front());
    exp_done++;
    step();
    chk("to_done_cnt", b.done_cnt, exp_done);
  endtask
  initial begin
    int n;
    int lmt;
    bit seen;
    b.enable = 1'b0;
    b.desc_vld = 1'b0;
    b.finish = 1'b0;
    b.timeout_limit = '0;
    reset_n = 1'b0;
    exp_done = '0;
    step();
    step();
    chk("rst_init", b.init_pulse, 0);
    chk("rst_done", b.job_done, 0);
    chk("rst_tag", b.job_tag, 0);
    chk("rst_err", b.job_err, 0);
    chk("rst_cnt", b.done_cnt, 0);
    chk("rst_busy", b.busy, 0);
    chk("rst_qlvl", b.q_level, 0);
    chk("rst_cfg", dut_cfg(), 0);
    chk("rst_rdy", b.desc_rdy, 0);
    reset_n = 1'b1;
    step();
    chk("post_rst_rdy", b.desc_rdy, 1);
    b.enable = 1'b1;
    b.timeout_limit = TOW'(1000);
    // single job: accept in cycle 0, pop in 1, LOAD in 2, kick in 3, finish 20 cycles after kick
    offer(rnd_job(8'h5A, AW'(3)));
    step();
    chk("sj_qlvl1", b.q_level, 1);
    chk("sj_noinit1", b.init_pulse, 0);
    step();
    chk("sj_busy", b.busy, 1);
    chk("sj_cfg_load", dut_cfg(), job_cfg(exp_q[0]));
    chk("sj_qlvl0", b.q_level, 0);
    step();
    chk("sj_init", b.init_pulse, 1);
    step();
    chk("sj_init_once", b.init_pulse, 0);
    finish_job(19, 1'b0);
    // zero-length job completes without an engine kick
    offer(rnd_job(8'($urandom), '0));
    step();
    n = 1;
    seen = 1'b0;
    while (b.job_done !== 1'b1 && n < 20) begin
      step();
      n++;
      if (b.init_pulse === 1'b1) seen = 1'b1;
    end
    chk("zl_latency", n, 3);
    chk("zl_no_init", seen, 0);
    chk("zl_tag", b.job_tag, exp_q[0].tag);
    chk("zl_err", b.job_err, 0);
    chk("zl_cfg", dut_cfg(), job_cfg(exp_q[0]));
    void'(exp_q.pop_front());
    exp_done++;
    step();
    chk("zl_cnt", b.done_cnt, exp_done);
    // finish during KICK is ignored
    offer(rnd_job(8'($urandom), nz()));
    step();
    wait_init(n);
    chk("start_latency", n, 2);
    finish_job(6, 1'b1);
    // queue full while job 0 runs; fifth descriptor waits for the first pop
    offer(rnd_job(8'd0, nz()));
    step();
    wait_init(n);
    for (int t = 1; t <= 4; t++) begin
      offer(rnd_job(8'(t), nz()));
      chk("qf_rdy", b.desc_rdy, 1);
      step();
    end
    chk("qf_qlvl4", b.q_level, 4);
    chk("qf_rdy_full", b.desc_rdy, 0);
    offer(rnd_job(8'd5, nz()));
    step();
    step();
    chk("qf_held_qlvl", b.q_level, 4);
    finish_job(1, 1'b0);
    chk("qf_rdy_idle", b.desc_rdy, 0);
    step();
    chk("qf_rdy_pop", b.desc_rdy, 1);
    chk("qf_qlvl3", b.q_level, 3);
    step();
    chk("qf_b2b_init", b.init_pulse, 1);
    chk("qf_fifth_in", b.q_level, 4);
    finish_job($urandom_range(1, 15), 1'b0);
    for (int t = 2; t <= 5; t++) begin
      wait_init(n);
      chk("b2b_gap", n, 2);
      finish_job($urandom_range(1, 15), 1'b0);
    end
    // timeout with limit 10, then a normal job
    b.timeout_limit = TOW'(10);
    offer(rnd_job(8'($urandom), nz()));
    step();
    wait_init(n);
    timeout_job(10);
    b.timeout_limit = TOW'(1000);
    offer(rnd_job(8'($urandom), nz()));
    step();
    wait_init(n);
    finish_job(4, 1'b0);
    // random-limit timeout
    lmt = $urandom_range(1, 30);
    b.timeout_limit = TOW'(lmt);
    offer(rnd_job(8'($urandom), nz()));
    step();
    wait_init(n);
    timeout_job(lmt);
    // finish coincident with the timeout cycle wins
    lmt = $urandom_range(3, 20);
    b.timeout_limit = TOW'(lmt);
    offer(rnd_job(8'($urandom), nz()));
    step();
    wait_init(n);
    finish_job(lmt, 1'b0);
    // limit 0 disables the watchdog
    b.timeout_limit = '0;
    offer(rnd_job(8'($urandom), nz()));
    step();
    wait_init(n);
    seen = 1'b0;
    repeat (1000) begin
      step();
      if (b.job_done === 1'b1) seen = 1'b1;
    end
    chk("no_to_1000", seen, 0);
    finish_job(1, 1'b0);
    // enable dropped mid-run: current job completes, next one waits
    b.timeout_limit = TOW'(1000);
    offer(rnd_job(8'($urandom), nz()));
    step();
    offer(rnd_job(8'($urandom), nz()));
    step();
    wait_init(n);
    b.enable = 1'b0;
    finish_job(5, 1'b0);
    seen = 1'b0;
    repeat (10) begin
      step();
      if (b.init_pulse === 1'b1 || b.busy === 1'b1) seen = 1'b1;
    end
    chk("en_held", seen, 0);
    chk("en_qlvl", b.q_level, 1);
    b.enable = 1'b1;
    wait_init(n);
    chk("en_resume", n, 2);
    finish_job(3, 1'b0);
    // reset mid-run clears outputs and flushes the queue
    offer(rnd_job(8'($urandom), nz()));
    step();
    offer(rnd_job(8'($urandom), nz()));
    step();
    wait_init(n);
    step();
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    exp_q.delete();
    exp_done = '0;
    chk("mr_init", b.init_pulse, 0);
    chk("mr_done", b.job_done, 0);
    chk("mr_tag", b.job_tag, 0);
    chk("mr_err", b.job_err, 0);
    chk("mr_cnt", b.done_cnt, 0);
    chk("mr_busy", b.busy, 0);
    chk("mr_qlvl", b.q_level, 0);
    chk("mr_cfg", dut_cfg(), 0);
    step();
    chk("mr_rdy", b.desc_rdy, 1);
    chk("mr_idle", b.busy, 0);
    offer(rnd_job(8'($urandom), nz()));
    step();
    wait_init(n);
    chk("mr_restart", n, 2);
    finish_job(2, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
